// File: rtl/wb_slave_pkg.sv
// Shared types and default widths for the Wishbone SRAM slave.
// Holds the controller state encoding and the bus width defaults.
package wb_slave_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_TERM = 2'd3
  } wb_state_t;

endpackage

// File: rtl/wb_sram_mem.sv
// Byte-enabled word storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module wb_sram_mem #(
  parameter int DW    = 32,
  parameter int WORDS = 256
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(WORDS)-1:0] i_idx,
  input  logic [DW-1:0]            i_wdata,
  input  logic [DW/8-1:0]          i_sel,
  output logic [DW-1:0]            o_rdata
);

  logic [DW-1:0] r_mem [WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (i_sel[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone SRAM slave: address decode, wait-state counter and termination FSM
// in front of a byte-enabled word memory.
module wb_sram_slave
  import wb_slave_pkg::*;
#(
  parameter int             DW          = DEF_DW,
  parameter int             AW          = DEF_AW,
  parameter int             MEM_WORDS   = 256,
  parameter logic [AW-1:0]  BASE_ADDR   = '0,
  parameter int             WAIT_STATES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic [DW-1:0]   s_dat_o,
  input  logic [AW-1:0]   s_adr_i,
  input  logic [DW/8-1:0] s_sel_i,
  input  logic            s_we_i,
  input  logic            s_cyc_i,
  input  logic            s_stb_i,
  input  logic            s_cab_i,
  output logic            s_ack_o,
  output logic            s_err_o,
  output logic            s_rty_o,
  input  logic            busy_i,
  output wb_state_t       o_dbg_state
);

  localparam int BYTES = DW / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IW    = $clog2(MEM_WORDS);

  localparam logic [AW:0]   BASE_X     = {1'b0, BASE_ADDR};
  localparam logic [AW:0]   SPAN_X     = (AW+1)'(MEM_WORDS * BYTES);
  localparam logic [AW:0]   LIMIT_X    = BASE_X + SPAN_X;
  localparam logic [AW-1:0] ALIGN_MASK = AW'(BYTES - 1);
  localparam logic [3:0]    WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // One extra bit keeps BASE+size and address+stride from wrapping into range.
  function automatic logic addr_ok(input logic [AW:0] a);
    return (a >= BASE_X) && (a < LIMIT_X) && ((a[AW-1:0] & ALIGN_MASK) == '0);
  endfunction

  wb_state_t  r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_ack, r_err, r_rty;
  logic       w_ack_nxt, w_err_nxt, w_rty_nxt;

  logic [AW:0]   w_adr_x, w_next_x;
  logic          w_cur_ok, w_next_ok;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_rdata;
  logic          w_mem_we;

  assign w_adr_x   = {1'b0, s_adr_i};
  assign w_next_x  = w_adr_x + (AW+1)'(BYTES);
  assign w_cur_ok  = addr_ok(w_adr_x);
  assign w_next_ok = addr_ok(w_next_x);
  assign w_idx     = IW'((s_adr_i - BASE_ADDR) >> OFF_W);

  // Handshake: a request is cyc&stb seen in IDLE; a beat completes on the clock
  // edge that ends the cycle in which ack is high, and that edge commits writes.
  // During a cab burst the master moves to the next word right after each ack.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rty_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          if (!w_cur_ok) begin
            w_state_nxt = ST_TERM;
            w_err_nxt   = 1'b1;
          end else if (busy_i) begin
            w_state_nxt = ST_TERM;
            w_rty_nxt   = 1'b1;
          end else if (WAIT_STATES == 0) begin
            w_state_nxt = ST_ACK;
            w_ack_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!s_cyc_i) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = ST_ACK;
          w_ack_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ACK: begin
        // The upcoming burst address is predicted; a bad one is errored from IDLE.
        if (s_cab_i && s_cyc_i && s_stb_i && w_next_ok) begin
          w_ack_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_TERM: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rty   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_rty   <= w_rty_nxt;
    end
  end

  // Reset clears r_ack asynchronously, so an in-flight write never commits.
  assign w_mem_we = r_ack && s_we_i && s_cyc_i && s_stb_i;

  wb_sram_mem #(
    .DW    (DW),
    .WORDS (MEM_WORDS)
  ) u_mem (
    .i_clk   (clk_i),
    .i_we    (w_mem_we),
    .i_idx   (w_idx),
    .i_wdata (s_dat_i),
    .i_sel   (s_sel_i),
    .o_rdata (w_rdata)
  );

  assign s_dat_o     = r_ack ? w_rdata : '0;
  assign s_ack_o     = r_ack;
  assign s_err_o     = r_err;
  assign s_rty_o     = r_rty;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: single transfers, byte lanes, decode errors,
// retry, a cab burst, abort and asynchronous reset, checked against a scoreboard.
module tb_wb_sram_slave;
  import wb_slave_pkg::*;

  localparam int         TO     = 40;
  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_ACK  = 2'd1;
  localparam logic [1:0] T_ERR  = 2'd2;
  localparam logic [1:0] T_RTY  = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] s_dat_i, s_dat_o, s_adr_i;
  logic [3:0]  s_sel_i;
  logic        s_we_i, s_cyc_i, s_stb_i, s_cab_i;
  logic        s_ack_o, s_err_o, s_rty_o, busy_i;
  wb_state_t   o_dbg_state;

  // Scoreboard entry: {term[1:0], latency[7:0], read data[31:0]}
  logic [41:0] exp_q[$];
  logic [41:0] e;
  logic [31:0] model [256];
  int          checks = 0;
  int          errors = 0;
  int          lat;
  int          seen;

  wb_sram_slave #(
    .DW(32), .AW(32), .MEM_WORDS(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_adr_i(s_adr_i), .s_sel_i(s_sel_i),
    .s_we_i(s_we_i), .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_cab_i(s_cab_i),
    .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_rty_o(s_rty_o),
    .busy_i(busy_i), .o_dbg_state(o_dbg_state)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] obs_term();
    if ((32'(s_ack_o) + 32'(s_err_o) + 32'(s_rty_o)) > 1) return 2'bxx;
    if (s_ack_o) return T_ACK;
    if (s_err_o) return T_ERR;
    if (s_rty_o) return T_RTY;
    return T_NONE;
  endfunction

  task automatic bus_idle();
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0; s_cab_i = 1'b0;
    s_adr_i = '0; s_dat_i = '0; s_sel_i = '0; busy_i = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input logic busy, input bit toggle_busy);
    logic [1:0]  et;
    logic [7:0]  el;
    logic [31:0] ed;
    logic [41:0] ent;
    int          n;
    if (adr >= 32'h400 || adr[1:0] != 2'b00) et = T_ERR;
    else if (busy)                           et = T_RTY;
    else                                     et = T_ACK;
    el = (et == T_ACK) ? 8'd3 : 8'd1;
    ed = (et == T_ACK && !we) ? model[adr[9:2]] : 32'h0;
    exp_q.push_back({et, el, ed});
    if (et == T_ACK && we)
      for (int b = 0; b < 4; b++)
        if (sel[b]) model[adr[9:2]][b*8 +: 8] = dat[b*8 +: 8];
    @(posedge clk_i); #1;
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we; s_adr_i = adr;
    s_dat_i = dat; s_sel_i = sel; s_cab_i = 1'b0; busy_i = busy;
    n = 0;
    do begin
      @(posedge clk_i); n++;
      @(negedge clk_i);
      if (toggle_busy) busy_i = ~busy_i;
    end while (obs_term() == T_NONE && n < TO);
    ent = exp_q.pop_front();
    check({tag, "_term"}, 64'(obs_term()), 64'(ent[41:40]));
    check({tag, "_lat"}, 64'(n), 64'(ent[39:32]));
    if (!we || ent[41:40] != T_ACK) check({tag, "_data"}, 64'(s_dat_o), 64'(ent[31:0]));
    @(posedge clk_i); #1;
    bus_idle();
    @(negedge clk_i);
    check({tag, "_pulse"}, 64'({obs_term(), s_dat_o}), 64'(0));
  endtask

  initial begin
    bus_idle();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_term",  64'({s_ack_o, s_err_o, s_rty_o}), 64'(0));
    check("rst_dat",   64'(s_dat_o), 64'(0));
    check("rst_state", 64'(o_dbg_state), 64'(ST_IDLE));
    rst_i = 1'b0;

    xfer("wr_10",   1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    xfer("rd_10",   1'b0, 32'h10, 32'h0,        4'hF, 1'b0, 1'b0);
    xfer("wr_lane", 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, 1'b0);
    xfer("rd_lane", 1'b0, 32'h10, 32'h0,        4'hF, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++)
      xfer("wr_bst", 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i * 32'h0101), 4'hF, 1'b0, 1'b0);
    xfer("wr_top",  1'b1, 32'h3FC, 32'h5A5A_1234, 4'hF, 1'b0, 1'b0);
    xfer("rd_top",  1'b0, 32'h3FC, 32'h0,         4'hF, 1'b0, 1'b0);

    xfer("err_400", 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
    xfer("rd_0",    1'b0, 32'h0,   32'h0,         4'hF, 1'b0, 1'b0);
    xfer("err_003", 1'b1, 32'h3,   32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
    xfer("rty_10",  1'b1, 32'h10,  32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0);
    xfer("rd_rty",  1'b0, 32'h10,  32'h0,         4'hF, 1'b0, 1'b0);
    xfer("wr_bsyw", 1'b1, 32'h20,  32'h0BAD_F00D, 4'hF, 1'b0, 1'b1);
    xfer("rd_bsyw", 1'b0, 32'h20,  32'h0,         4'hF, 1'b0, 1'b0);

    // cab burst read of words 0..3; the last beat drops cab
    for (int i = 0; i < 4; i++)
      exp_q.push_back({T_ACK, (i == 0) ? 8'd3 : 8'd1, model[i]});
    @(posedge clk_i); #1;
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_sel_i = 4'hF;
    s_adr_i = 32'h0; s_cab_i = 1'b1;
    for (int beat = 0; beat < 4; beat++) begin
      lat = 0;
      do begin
        @(posedge clk_i); lat++;
        if (lat == 1 && beat > 0) begin
          #1;
          s_adr_i = 32'(beat * 4);
          s_cab_i = (beat < 3);
        end
        @(negedge clk_i);
      end while (obs_term() == T_NONE && lat < TO);
      e = exp_q.pop_front();
      check("burst_term", 64'(obs_term()), 64'(e[41:40]));
      check("burst_lat",  64'(lat), 64'(e[39:32]));
      check("burst_data", 64'(s_dat_o), 64'(e[31:0]));
    end
    @(posedge clk_i); #1;
    bus_idle();
    @(negedge clk_i);
    check("burst_end", 64'({obs_term(), s_dat_o}), 64'(0));

    // cyc dropped during WAIT: no termination, no write
    @(posedge clk_i); #1;
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_adr_i = 32'h10;
    s_dat_i = 32'h5555_5555; s_sel_i = 4'hF;
    @(posedge clk_i);
    @(negedge clk_i);
    check("abort_wait", 64'(o_dbg_state), 64'(ST_WAIT));
    bus_idle();
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (obs_term() != T_NONE) seen++;
    end
    check("abort_term", 64'(seen), 64'(0));
    check("abort_idle", 64'(o_dbg_state), 64'(ST_IDLE));
    xfer("rd_abort", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0);

    // reset pulsed mid-WAIT
    @(posedge clk_i); #1;
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_adr_i = 32'h10; s_sel_i = 4'hF;
    @(posedge clk_i);
    @(negedge clk_i);
    check("rstw_wait", 64'(o_dbg_state), 64'(ST_WAIT));
    rst_i = 1'b1; #1;
    check("rstw_state", 64'(o_dbg_state), 64'(ST_IDLE));
    check("rstw_out",   64'({obs_term(), s_dat_o}), 64'(0));
    bus_idle();
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // reset while a write is in its ACK cycle: write discarded
    @(posedge clk_i); #1;
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_adr_i = 32'h10;
    s_dat_i = 32'hCAFE_F00D; s_sel_i = 4'hF;
    lat = 0;
    do begin
      @(posedge clk_i); lat++;
      @(negedge clk_i);
    end while (!s_ack_o && lat < TO);
    check("rsta_ack", 64'(s_ack_o), 64'(1));
    rst_i = 1'b1; #1;
    check("rsta_out",   64'({obs_term(), s_dat_o}), 64'(0));
    check("rsta_state", 64'(o_dbg_state), 64'(ST_IDLE));
    @(posedge clk_i); #1;
    bus_idle();
    rst_i = 1'b0;
    xfer("rd_rsta", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_sram_slave.md
WB_SRAM_SLAVE -- requirements
Module: wb_sram_slave

Interface
REQ-001 Parameter DW, 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, 32, address width in bits.
REQ-003 Parameter MEM_WORDS, 256, memory depth in DW-bit words; SHALL be a power of two.
REQ-004 Parameter BASE_ADDR, 32'h0000_0000, byte address of word 0; SHALL be aligned to MEM_WORDS*DW/8.
REQ-005 Parameter WAIT_STATES, 2, idle cycles inserted before the first ACK of a cycle; range 0..15.
REQ-006 clk_i  in  1  single clock; all state SHALL change on its rising edge.
REQ-007 rst_i  in  1  reset; asynchronous and active-high.
REQ-008 s_dat_i  in  DW  write data from the conbus slave port.
REQ-009 s_dat_o  out  DW  read data to the conbus.
REQ-010 s_adr_i  in  AW  byte address.
REQ-011 s_sel_i  in  DW/8  byte-lane enables.
REQ-012 s_we_i  in  1  1 = write, 0 = read.
REQ-013 s_cyc_i  in  1  bus cycle active.
REQ-014 s_stb_i  in  1  strobe.
REQ-015 s_cab_i  in  1  consecutive-address burst hint.
REQ-016 s_ack_o  out  1  normal termination.
REQ-017 s_err_o  out  1  error termination.
REQ-018 s_rty_o  out  1  retry termination.
REQ-019 busy_i  in  1  memory owned elsewhere; a new request SHALL be answered with retry.

Function
REQ-020 The block SHALL use a four-state FSM: IDLE, WAIT, ACK, TERM.
REQ-021 The block SHALL recognise a request only when s_cyc_i & s_stb_i are high in IDLE.
REQ-022 Decode error: a request SHALL be errored if s_adr_i < BASE_ADDR, s_adr_i >= BASE_ADDR + MEM_WORDS*DW/8, or its byte-offset bits are nonzero.
REQ-023 IDLE transitions SHALL take the first matching row, in this priority order:
- decode error -> TERM with s_err_o = 1;
- else busy_i = 1 -> TERM with s_rty_o = 1;
- else WAIT_STATES = 0 -> ACK;
- else WAIT, with the wait counter loaded to WAIT_STATES-1.
REQ-024 In WAIT, the counter SHALL decrement each cycle and the FSM SHALL move to ACK on the cycle the counter reads 0.
REQ-025 The first ACK SHALL be asserted exactly WAIT_STATES+1 cycles after the request is sampled.
REQ-026 s_ack_o, s_err_o and s_rty_o SHALL be registered, mutually exclusive, and each high for exactly one cycle per beat.
REQ-027 TERM SHALL last one cycle, then return to IDLE.
REQ-028 Write timing: a write SHALL update only the byte lanes with s_sel_i = 1, at the word addressed by s_adr_i, on the clock edge that ends the ACK cycle.
REQ-029 Read data: s_dat_o SHALL equal the addressed word (combinational read) while s_ack_o = 1, and SHALL be 0 otherwise.
REQ-030 ACK exit when s_cab_i & s_cyc_i & s_stb_i are high and the next address decodes validly: the FSM SHALL stay in ACK, giving zero-wait back-to-back beats.
REQ-031 ACK exit otherwise: the FSM SHALL go to IDLE, and a burst beat that decodes invalidly SHALL be reported through IDLE as an error.
REQ-032 If s_cyc_i falls in WAIT, the FSM SHALL abort to IDLE with no write and no termination signal.
REQ-033 Address wrap: the word index SHALL be (s_adr_i - BASE_ADDR) >> log2(DW/8); burst beats are never wrapped, because out-of-range addresses error per REQ-022.
REQ-034 busy_i SHALL be sampled only in IDLE; busy_i rising mid-transaction SHALL NOT affect that transaction.

Reset
REQ-035 Asserting rst_i SHALL immediately force state IDLE, counter 0, s_ack_o/s_err_o/s_rty_o = 0 and s_dat_o = 0, including mid-transaction.
REQ-036 Memory contents SHALL NOT be reset.
REQ-037 Any write not yet committed when reset asserts SHALL be discarded.

Structure
REQ-038 Package wb_slave_pkg SHALL hold the FSM state enum and the default DW/AW constants.
REQ-039 Storage SHALL live in sub-module wb_sram_mem: a byte-enabled register array with one synchronous write port and one combinational read port.
REQ-040 The FSM, decode and wait counter SHALL reside in wb_sram_slave.

Verification
REQ-041 Write/read with WAIT_STATES=2: write 32'hDEADBEEF to 0x10 with sel=4'hF, then read 0x10 -> each ACK 3 cycles after stb, read data 32'hDEADBEEF.
REQ-042 Byte lanes: write 32'h11223344 with sel=4'b0101 over 32'hDEADBEEF -> read returns 32'hDE22BE44.
REQ-043 Errors: address BASE+0x400 with MEM_WORDS=256 -> s_err_o 1 cycle after stb, no write; address 0x3 -> s_err_o.
REQ-044 Retry: busy_i=1 at request -> s_rty_o for one cycle and memory unchanged; busy_i toggled during WAIT -> normal ACK.
REQ-045 Burst: cab=1 reads of 0x0, 0x4, 0x8, 0xC -> first ACK at WAIT_STATES+1, then three consecutive ACK cycles with correct data.
REQ-046 Abort and reset: cyc dropped in WAIT -> no ACK and no write; rst_i pulsed mid-WAIT -> outputs 0 immediately, FSM in IDLE.
